// File: rtl/layer_mixer_if.sv
// layer_mixer_if
//  Pixel-rate bundle between the timing source, the background ROM and the
//  layer compositor.
//  master : drives raster position/sync/sprite inputs and background ROM data,
//           receives composited colour, syncs, scroll and collision state.
//  slave  : the compositor side (layer_mixer).
//  There is no handshake. One pixel is transferred on every clock and both
//  sides are always ready. The ROM returns bg_q a fixed number of cycles after
//  bg_addr.
interface layer_mixer_if #(
  parameter int NUM_SPRITES = 4,
  parameter int COL_W       = 12,
  parameter int ROW_W       = 11,
  parameter int SCROLL_W    = 32,
  parameter int BG_ADDR_W   = 16
);
  logic [COL_W-1:0]          display_col;
  logic [ROW_W-1:0]          display_row;
  logic                      visible;
  logic                      hsync_in;
  logic                      vsync_in;
  logic                      scroll_en;
  logic [NUM_SPRITES-1:0]    sprite_visible;
  logic [12*NUM_SPRITES-1:0] sprite_rgb;
  logic [BG_ADDR_W-1:0]      bg_addr;
  logic [11:0]               bg_q;
  logic [3:0]                vga_r;
  logic [3:0]                vga_g;
  logic [3:0]                vga_b;
  logic                      hsync_out;
  logic                      vsync_out;
  logic [SCROLL_W-1:0]       scroll_pos;
  logic                      frame_tick;
  logic [NUM_SPRITES-1:0]    collision;

  modport master (
    output display_col, display_row, visible, hsync_in, vsync_in, scroll_en,
           sprite_visible, sprite_rgb, bg_q,
    input  bg_addr, vga_r, vga_g, vga_b, hsync_out, vsync_out, scroll_pos,
           frame_tick, collision
  );

  modport slave (
    input  display_col, display_row, visible, hsync_in, vsync_in, scroll_en,
           sprite_visible, sprite_rgb, bg_q,
    output bg_addr, vga_r, vga_g, vga_b, hsync_out, vsync_out, scroll_pos,
           frame_tick, collision
  );
endinterface

// File: rtl/layer_mixer.sv
// layer_mixer
//  Per-pixel layer compositor between the VGA timing generator and the pins.
//  Produces the scrolled background ROM address, delays sprite/sync data to
//  line up with the ROM read, picks the lowest-index opaque sprite over the
//  background, and reports per-frame sprite-0 overlaps.
// Ports
//  clock : pixel clock
//  reset : asynchronous, active-low
//  bus   : layer_mixer_if.slave (raster inputs, sprites, ROM address/data,
//          colour/sync outputs, scroll_pos, frame_tick, collision)
module layer_mixer #(
  parameter int          NUM_SPRITES = 4,
  parameter int          COL_W       = 12,
  parameter int          ROW_W       = 11,
  parameter int          SCROLL_W    = 32,
  parameter int          SCROLL_STEP = 3,
  parameter int          BG_SHIFT    = 2,
  parameter int          BG_COL_BITS = 8,
  parameter int          BG_ROW_BITS = 8,
  parameter int          BG_LATENCY  = 1,
  parameter bit          KEY_EN      = 1'b1,
  parameter logic [11:0] KEY_COLOR   = 12'h000
) (
  input logic         clock,
  input logic         reset,
  layer_mixer_if.slave bus
);

  localparam int EXT_W = (SCROLL_W > COL_W) ? SCROLL_W : COL_W;

  typedef struct packed {
    logic [NUM_SPRITES-1:0]    eff;
    logic [12*NUM_SPRITES-1:0] rgb;
    logic                      vis;
    logic                      hs;
    logic                      vs;
  } pix_t;

  logic [SCROLL_W-1:0]    scroll_q;
  logic                   tick_q;
  logic [NUM_SPRITES-1:0] acc_q;
  logic [NUM_SPRITES-1:0] coll_q;
  logic [11:0]            rgb_q;
  logic                   hs_q;
  logic                   vs_q;

  logic                   frame_start;
  logic [EXT_W-1:0]       scroll_ext;
  logic [COL_W-1:0]       sc;
  logic [NUM_SPRITES-1:0] eff;
  logic [NUM_SPRITES-1:0] hit;
  logic [11:0]            colour;
  logic                   unused_bits;
  pix_t                   cur;
  pix_t                   sel;
  pix_t                   pipe [BG_LATENCY];

  assign frame_start = (bus.display_col == '0) && (bus.display_row == '0);

  // Scroll may be narrower than the column counter; zero-extend before
  // taking the low COL_W bits so the add wraps at 2^COL_W.
  assign scroll_ext = EXT_W'(scroll_q);
  assign sc         = bus.display_col + scroll_ext[COL_W-1:0];
  assign bus.bg_addr = {sc[BG_SHIFT+BG_COL_BITS-1:BG_SHIFT],
                        bus.display_row[BG_SHIFT+BG_ROW_BITS-1:BG_SHIFT]};
  assign unused_bits = ^{sc, bus.display_row, scroll_ext};

  // Colour keying happens at the input so both the priority mux and the
  // collision detector see the same effective visibility.
  always_comb begin
    eff = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      eff[i] = bus.sprite_visible[i] &&
               !(KEY_EN && (bus.sprite_rgb[12*i +: 12] == KEY_COLOR));
    end
  end

  // Player (sprite 0) against every other sprite; bit 0 never set.
  always_comb begin
    hit = '0;
    for (int j = 1; j < NUM_SPRITES; j++) begin
      hit[j] = bus.visible && eff[0] && eff[j];
    end
  end

  assign cur = '{eff: eff, rgb: bus.sprite_rgb, vis: bus.visible,
                 hs: bus.hsync_in, vs: bus.vsync_in};

  // Delay line matching the background ROM read latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BG_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < BG_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign sel = pipe[BG_LATENCY-1];

  // Scan from highest index down so the lowest-index opaque sprite wins.
  always_comb begin
    colour = bus.bg_q;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (sel.eff[i]) colour = sel.rgb[12*i +: 12];
    end
    if (!sel.vis) colour = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= colour;
      hs_q  <= sel.hs;
      vs_q  <= sel.vs;
    end
  end

  // Frame-rate state. The (0,0) pixel's hit seeds the new accumulator, and
  // the completed frame's flags are published for the whole next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scroll_q <= '0;
      tick_q   <= 1'b0;
      acc_q    <= '0;
      coll_q   <= '0;
    end else begin
      tick_q <= frame_start;
      if (frame_start && bus.scroll_en) scroll_q <= scroll_q + SCROLL_W'(SCROLL_STEP);
      if (frame_start) begin
        coll_q <= acc_q;
        acc_q  <= hit;
      end else begin
        acc_q  <= acc_q | hit;
      end
    end
  end

  assign bus.vga_r      = rgb_q[3:0];
  assign bus.vga_g      = rgb_q[7:4];
  assign bus.vga_b      = rgb_q[11:8];
  assign bus.hsync_out  = hs_q;
  assign bus.vsync_out  = vs_q;
  assign bus.scroll_pos = scroll_q;
  assign bus.frame_tick = tick_q;
  assign bus.collision  = coll_q;

endmodule
